// File: rtl/aud_pkg.sv
// Shared types for the WM8731 audio path: stereo frame, LR slot, attenuation helper.
// No logic of its own; no latency or backpressure.
// Imported by aud_sample_fifo and aud_dac_tx.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef struct packed {
        logic [AUD_DATA_W-1:0] left;
        logic [AUD_DATA_W-1:0] right;
    } aud_frame_t;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } lr_slot_e;

    // Arithmetic shift: sign kept, truncates toward minus infinity (-1 stays -1).
    function automatic logic [AUD_DATA_W-1:0] aud_atten(
        input logic [AUD_DATA_W-1:0] word,
        input logic [3:0]            shamt
    );
        return $signed(word) >>> shamt;
    endfunction

endpackage

// File: rtl/aud_sample_fifo.sv
// Synchronous FIFO of stereo frames, DEPTH entries, wrap-bit pointers.
// Latency: a pushed frame is visible at the read port the cycle after the push.
// Backpressure: o_full blocks pushes; pops while empty are ignored.
module aud_sample_fifo
    import aud_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  aud_frame_t               i_push_dat,
    input  logic                     i_pop,
    output aud_frame_t               o_pop_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    aud_frame_t  mem [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        push_ok;
    logic        pop_ok;

    assign o_count   = wr_q - rd_q;
    assign o_empty   = (wr_q == rd_q);
    assign o_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_pop_dat = mem[rd_q[AW-1:0]];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (AW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_q[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/aud_dac_tx.sv
// I2S DAC transmitter: FIFO-buffered stereo frames serialized MSB-first against codec DACLRCK; AUD_DAC_TX_ATTEN_EN adds i_atten.
// Latency: LRCK edge seen at cycle N -> MSB on o_dacdat at N+1, LSB at N+DATA_W; underrun pulse at N+1.
// Backpressure: o_ready = !full from the registered FIFO count; an empty FIFO at a left slot plays silence.
module aud_dac_tx
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    input  logic              i_daclrck,
    output logic              o_dacdat,
    output logic              o_underrun,
    output logic [7:0]        o_underrun_cnt
`ifdef AUD_DAC_TX_ATTEN_EN
    ,
    input  logic [3:0]        i_atten
`endif
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    aud_frame_t        wr_frame;
    aud_frame_t        rd_frame;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_push;
    logic              fifo_pop;

    logic              lrck_q;
    logic              armed_q;
    logic              lrck_edge;
    logic              lrck_fall;
    logic              lrck_rise;
    lr_slot_e          new_slot;

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        urun_cnt_q, urun_cnt_d;
    logic [DATA_W-1:0] pop_left;
    logic [DATA_W-1:0] pop_right;

    assign wr_frame.left  = i_left;
    assign wr_frame.right = i_right;
    assign o_ready        = !fifo_full;
    assign fifo_push      = i_valid && o_ready;

    aud_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (fifo_push),
        .i_push_dat (wr_frame),
        .i_pop      (fifo_pop),
        .o_pop_dat  (rd_frame),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_count    (fifo_cnt)
    );

    // armed_q masks the compare on the first cycle out of reset, before lrck_q has tracked the pin.
    assign new_slot  = lr_slot_e'(i_daclrck);
    assign lrck_edge = armed_q && (i_daclrck != lrck_q);
    assign lrck_fall = lrck_edge && (new_slot == SLOT_LEFT);
    assign lrck_rise = lrck_edge && (new_slot == SLOT_RIGHT);
    assign fifo_pop  = lrck_fall && i_enable && !fifo_empty;

`ifdef AUD_DAC_TX_ATTEN_EN
    assign pop_left  = aud_atten(rd_frame.left, i_atten);
    assign pop_right = aud_atten(rd_frame.right, i_atten);
`else
    assign pop_left  = rd_frame.left;
    assign pop_right = rd_frame.right;
`endif

    always_comb begin
        sh_d       = sh_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        urun_cnt_d = urun_cnt_q;
        underrun_d = 1'b0;
        if (lrck_fall) begin
            bit_cnt_d = CNT_W'(DATA_W);
            if (fifo_pop) begin
                sh_d   = pop_left;
                hold_d = pop_right;
            end else begin
                sh_d   = '0;
                hold_d = '0;
            end
            if (i_enable && fifo_empty) begin
                underrun_d = 1'b1;
                if (urun_cnt_q != 8'hFF) urun_cnt_d = urun_cnt_q + 8'd1;
            end
        end else if (lrck_rise) begin
            sh_d      = hold_q;
            bit_cnt_d = CNT_W'(DATA_W);
        end else if (bit_cnt_q != '0) begin
            sh_d      = {sh_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q     <= 1'b0;
            armed_q    <= 1'b0;
            sh_q       <= '0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            lrck_q     <= i_daclrck;
            armed_q    <= 1'b1;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    // Output is gated by the bit counter so it reads zero once the slot's word is spent.
    assign o_dacdat       = sh_q[DATA_W-1] && (bit_cnt_q != '0);
    assign o_underrun     = underrun_q;
    assign o_underrun_cnt = urun_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) assert (fifo_cnt <= FCNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_aud_dac_tx.sv
// Directed bench for aud_dac_tx: vector table of stereo frames plus hand sequences for full/empty/short-slot/saturation/reset.
module tb_aud_dac_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_left;
    logic [15:0] i_right;
    logic        i_daclrck;
    logic        o_dacdat;
    logic        o_underrun;
    logic [7:0]  o_underrun_cnt;
`ifdef AUD_DAC_TX_ATTEN_EN
    logic [3:0]  i_atten;
`endif

    always #5 clk = ~clk;

    aud_dac_tx #(
        .DATA_W (16),
        .DEPTH  (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_left         (i_left),
        .i_right        (i_right),
        .i_daclrck      (i_daclrck),
        .o_dacdat       (o_dacdat),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt)
`ifdef AUD_DAC_TX_ATTEN_EN
        ,
        .i_atten        (i_atten)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        push;
        logic [15:0] l;
        logic [15:0] r;
        logic        en;
        logic [15:0] el;
        logic [15:0] er;
        int          eunf;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int t;
        t = 0;
        i_left  = l;
        i_right = r;
        i_valid = 1'b1;
        while (!o_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end
        tick();
        i_valid = 1'b0;
    endtask

    // Drive LRCK to lv, then sample len cycles; the first 16 samples form the word.
    task automatic run_slot(input logic lv, input int len, output logic [15:0] word,
                            output int nz, output int pulses, output logic rdy0);
        word   = '0;
        nz     = 0;
        pulses = 0;
        rdy0   = 1'b0;
        i_daclrck = lv;
        for (int j = 0; j < len; j++) begin
            tick();
            if (j == 0) begin
                rdy0    = o_ready;
                i_valid = 1'b0;
            end
            if (j < 16) word = {word[14:0], o_dacdat};
            else if (o_dacdat) nz++;
            if (o_underrun) pulses++;
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] el, input logic [15:0] er,
                             input int eunf);
        logic [15:0] wl, wr;
        int          nzl, nzr, pl, pr;
        logic        r0;
        run_slot(1'b0, 32, wl, nzl, pl, r0);
        run_slot(1'b1, 32, wr, nzr, pr, r0);
        chk({name, "_left"}, wl, el);
        chk({name, "_right"}, wr, er);
        chk({name, "_tail_zero"}, nzl + nzr, 0);
        chk({name, "_underrun"}, pl + pr, eunf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wl, wr;
        int          nz, pl;
        logic        r0;

        tbl[0] = '{1'b1, 16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE, 0, 8'd0};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1, 8'd1};
        tbl[2] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 16'hA5A5, 16'h5A5A, 0, 8'd1};
        tbl[3] = '{1'b1, 16'h1234, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 0, 8'd1};
        tbl[4] = '{1'b1, 16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h0000, 0, 8'd1};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'hFFFF, 0, 8'd1};
        tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h8000, 0, 8'd1};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1, 8'd2};

        rst_n     = 1'b1;
        i_enable  = 1'b1;
        i_valid   = 1'b0;
        i_left    = '0;
        i_right   = '0;
        i_daclrck = 1'b1;
`ifdef AUD_DAC_TX_ATTEN_EN
        i_atten   = 4'd0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dacdat", o_dacdat, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_underrun", o_underrun, 0);
        chk("rst_cnt", o_underrun_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_underrun", o_underrun, 0);
        chk("idle_dacdat", o_dacdat, 0);

        for (int i = 0; i < 8; i++) begin
            i_enable = tbl[i].en;
            if (tbl[i].push) push(tbl[i].l, tbl[i].r);
            run_frame($sformatf("vec%0d", i), tbl[i].el, tbl[i].er, tbl[i].eunf);
            chk($sformatf("vec%0d_cnt", i), o_underrun_cnt, tbl[i].ecnt);
        end

        // Full FIFO: 5th push held off, including during the pop cycle.
        i_enable = 1'b1;
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        push(16'h7777, 16'h8888);
        chk("full_ready", o_ready, 0);
        i_left  = 16'hDEAD;
        i_right = 16'hBEEF;
        i_valid = 1'b1;
        tick();
        tick();
        chk("full_reject_ready", o_ready, 0);
        run_slot(1'b0, 32, wl, nz, pl, r0);
        chk("full_pop_ready", r0, 1);
        chk("full_f0_left", wl, 16'h1111);
        run_slot(1'b1, 32, wr, nz, pl, r0);
        chk("full_f0_right", wr, 16'h2222);
        run_frame("full_f1", 16'h3333, 16'h4444, 0);
        run_frame("full_f2", 16'h5555, 16'h6666, 0);
        run_frame("full_f3", 16'h7777, 16'h8888, 0);
        run_frame("full_drained", 16'h0000, 16'h0000, 1);

        // Push coincident with a pop attempt on an empty FIFO.
        i_left  = 16'hCAFE;
        i_right = 16'h0BAD;
        i_valid = 1'b1;
        run_slot(1'b0, 32, wl, nz, pl, r0);
        chk("coinc_left_silent", wl, 16'h0000);
        chk("coinc_underrun", pl, 1);
        run_slot(1'b1, 32, wr, nz, pl, r0);
        chk("coinc_right_silent", wr, 16'h0000);
        run_frame("coinc_next", 16'hCAFE, 16'h0BAD, 0);
        chk("coinc_cnt", o_underrun_cnt, 4);

        // Short left slot: truncated after 8 bits, right word starts at once.
        push(16'hFFFF, 16'h8000);
        run_slot(1'b0, 8, wl, nz, pl, r0);
        chk("short_left_bits", wl, 16'h00FF);
        run_slot(1'b1, 32, wr, nz, pl, r0);
        chk("short_right", wr, 16'h8000);
        chk("short_right_tail", nz, 0);

`ifdef AUD_DAC_TX_ATTEN_EN
        i_atten = 4'd4;
        push(16'hF000, 16'hFFFF);
        run_frame("atten", 16'hFF00, 16'hFFFF, 0);
        i_atten = 4'd0;
`endif

        // Underrun counter saturation.
        repeat (300) begin
            i_daclrck = 1'b0;
            tick();
            tick();
            i_daclrck = 1'b1;
            tick();
            tick();
        end
        chk("sat_cnt", o_underrun_cnt, 255);

        // Reset mid-word.
        push(16'hFFFF, 16'hFFFF);
        i_daclrck = 1'b0;
        repeat (3) tick();
        chk("midrst_pre_dacdat", o_dacdat, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dacdat", o_dacdat, 0);
        chk("midrst_cnt", o_underrun_cnt, 0);
        chk("midrst_ready", o_ready, 1);
        i_daclrck = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_frame("post_rst", 16'h0000, 16'h0000, 1);
        chk("post_rst_cnt", o_underrun_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
